// File: rtl/nasti_pkg.sv
// Shared NASTI encodings and the burst master state type.
// Imported by the burst master and by anything that decodes its responses.
package nasti_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WDATA,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } master_state_t;

  // The first error seen in a burst sticks; later beats cannot clear it.
  function automatic logic [1:0] merge_resp(input logic [1:0] acc, input logic [1:0] beat);
    return (acc == RESP_OKAY) ? beat : acc;
  endfunction

endpackage

// File: rtl/nasti_if.sv
// Five-channel NASTI bundle with master and slave views.
// Widths follow the C_NASTI_* parameters of the block that owns the instance.
interface nasti_if #(
  parameter int ID_W   = 9,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int USER_W = 1
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_lock;
  logic [3:0]          aw_cache;
  logic [2:0]          aw_prot;
  logic [3:0]          aw_qos;
  logic [3:0]          aw_region;
  logic [USER_W-1:0]   aw_user;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_lock;
  logic [3:0]          ar_cache;
  logic [2:0]          ar_prot;
  logic [3:0]          ar_qos;
  logic [3:0]          ar_region;
  logic [USER_W-1:0]   ar_user;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid, output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid, input r_ready
  );
endinterface

// File: rtl/nasti_burst_master.sv
// Single-outstanding NASTI burst initiator: one command in, one INCR burst out,
// data streamed through local valid/ready ports, one completion pulse back.
module nasti_burst_master #(
  parameter int C_NASTI_ID_WIDTH   = 9,
  parameter int C_NASTI_ADDR_WIDTH = 32,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_NASTI_USER_WIDTH = 1
) (
  input  logic                            core_clk,
  input  logic                            core_arst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_NASTI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]                      cmd_len,
  input  logic [2:0]                      cmd_size,
  input  logic [C_NASTI_ID_WIDTH-1:0]     cmd_id,
  input  logic [C_NASTI_DATA_WIDTH-1:0]   wr_data,
  input  logic [C_NASTI_DATA_WIDTH/8-1:0] wr_strb,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  output logic [C_NASTI_DATA_WIDTH-1:0]   rd_data,
  output logic                            rd_last,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic                            done_valid,
  output logic [1:0]                      done_resp,
  output logic [C_NASTI_ID_WIDTH-1:0]     done_id,
  nasti_if.master                         m_nasti
);
  import nasti_pkg::*;

  master_state_t                 state_reg;
  logic [7:0]                    beat_reg;
  logic [C_NASTI_ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]                    len_reg;
  logic [2:0]                    size_reg;
  logic [C_NASTI_ID_WIDTH-1:0]   id_reg;
  logic [1:0]                    resp_reg;
  logic [1:0]                    done_resp_reg;
  logic [C_NASTI_ID_WIDTH-1:0]   done_id_reg;
  logic                          cmd_ready_reg;
  logic                          aw_valid_reg;
  logic                          ar_valid_reg;
  logic                          b_ready_reg;
  logic                          done_valid_reg;

  logic       w_phase, r_phase, w_hs, r_hs, beat_last;
  logic [1:0] r_resp_merged, r_final_resp;

  assign w_phase       = (state_reg == WDATA);
  assign r_phase       = (state_reg == RDATA);
  assign w_hs          = w_phase & wr_valid & m_nasti.w_ready;
  assign r_hs          = r_phase & m_nasti.r_valid & rd_ready;
  assign beat_last     = (beat_reg == len_reg);
  assign r_resp_merged = merge_resp(resp_reg, m_nasti.r_resp);
  // A last flag that disagrees with the beat count means the slave broke the burst.
  assign r_final_resp  = (m_nasti.r_last != beat_last) ? RESP_SLVERR : r_resp_merged;

  always_ff @(posedge core_clk or posedge core_arst) begin
    if (core_arst) begin
      state_reg      <= IDLE;
      beat_reg       <= 8'd0;
      addr_reg       <= '0;
      len_reg        <= 8'd0;
      size_reg       <= 3'd0;
      id_reg         <= '0;
      resp_reg       <= RESP_OKAY;
      done_resp_reg  <= RESP_OKAY;
      done_id_reg    <= '0;
      cmd_ready_reg  <= 1'b0;
      aw_valid_reg   <= 1'b0;
      ar_valid_reg   <= 1'b0;
      b_ready_reg    <= 1'b0;
      done_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (cmd_valid && cmd_ready_reg) begin
            addr_reg      <= cmd_addr;
            len_reg       <= cmd_len;
            size_reg      <= cmd_size;
            id_reg        <= cmd_id;
            resp_reg      <= RESP_OKAY;
            cmd_ready_reg <= 1'b0;
            if (cmd_write) begin
              aw_valid_reg <= 1'b1;
              state_reg    <= WADDR;
            end else begin
              ar_valid_reg <= 1'b1;
              state_reg    <= RADDR;
            end
          end
        end
        WADDR: begin
          if (m_nasti.aw_ready) begin
            aw_valid_reg <= 1'b0;
            beat_reg     <= 8'd0;
            state_reg    <= WDATA;
          end
        end
        WDATA: begin
          if (w_hs) begin
            beat_reg <= beat_reg + 8'd1;
            if (beat_last) begin
              b_ready_reg <= 1'b1;
              state_reg   <= WRESP;
            end
          end
        end
        WRESP: begin
          if (m_nasti.b_valid) begin
            b_ready_reg    <= 1'b0;
            done_resp_reg  <= m_nasti.b_resp;
            done_id_reg    <= m_nasti.b_id;
            done_valid_reg <= 1'b1;
            state_reg      <= DONE;
          end
        end
        RADDR: begin
          if (m_nasti.ar_ready) begin
            ar_valid_reg <= 1'b0;
            beat_reg     <= 8'd0;
            state_reg    <= RDATA;
          end
        end
        RDATA: begin
          if (r_hs) begin
            beat_reg <= beat_reg + 8'd1;
            resp_reg <= r_resp_merged;
            if (m_nasti.r_last || beat_last) begin
              done_resp_reg  <= r_final_resp;
              done_id_reg    <= m_nasti.r_id;
              done_valid_reg <= 1'b1;
              state_reg      <= DONE;
            end
          end
        end
        DONE: begin
          done_valid_reg <= 1'b0;
          cmd_ready_reg  <= 1'b1;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_reg;
  assign done_valid = done_valid_reg;
  assign done_resp  = done_resp_reg;
  assign done_id    = done_id_reg;

  assign m_nasti.aw_id     = id_reg;
  assign m_nasti.aw_addr   = addr_reg;
  assign m_nasti.aw_len    = len_reg;
  assign m_nasti.aw_size   = size_reg;
  assign m_nasti.aw_burst  = BURST_INCR;
  assign m_nasti.aw_lock   = 1'b0;
  assign m_nasti.aw_cache  = 4'd0;
  assign m_nasti.aw_prot   = 3'd0;
  assign m_nasti.aw_qos    = 4'd0;
  assign m_nasti.aw_region = 4'd0;
  assign m_nasti.aw_user   = {C_NASTI_USER_WIDTH{1'b0}};
  assign m_nasti.aw_valid  = aw_valid_reg;

  // W and R are pure passthroughs gated by state, so a reset kills them at once.
  assign m_nasti.w_data    = wr_data;
  assign m_nasti.w_strb    = wr_strb;
  assign m_nasti.w_last    = w_phase & beat_last;
  assign m_nasti.w_user    = {C_NASTI_USER_WIDTH{1'b0}};
  assign m_nasti.w_valid   = w_phase & wr_valid;
  assign wr_ready          = w_phase & m_nasti.w_ready;

  assign m_nasti.b_ready   = b_ready_reg;

  assign m_nasti.ar_id     = id_reg;
  assign m_nasti.ar_addr   = addr_reg;
  assign m_nasti.ar_len    = len_reg;
  assign m_nasti.ar_size   = size_reg;
  assign m_nasti.ar_burst  = BURST_INCR;
  assign m_nasti.ar_lock   = 1'b0;
  assign m_nasti.ar_cache  = 4'd0;
  assign m_nasti.ar_prot   = 3'd0;
  assign m_nasti.ar_qos    = 4'd0;
  assign m_nasti.ar_region = 4'd0;
  assign m_nasti.ar_user   = {C_NASTI_USER_WIDTH{1'b0}};
  assign m_nasti.ar_valid  = ar_valid_reg;

  assign rd_data           = m_nasti.r_data;
  assign rd_last           = r_phase & m_nasti.r_last;
  assign rd_valid          = r_phase & m_nasti.r_valid;
  assign m_nasti.r_ready   = r_phase & rd_ready;

endmodule
